qc_rot_pipe: RTL and testbench

//  Pipelined, runtime-configurable cyclic rotator for the QC-LDPC decoder datapath. It rotates one

---
 rtl/qc_rot_pkg.sv | 16 +
 rtl/qc_rot_lane_sel.sv | 33 +++
 rtl/qc_rot_pipe.sv | 141 ++++++++++++++
 tb/tb_qc_rot_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qc_rot_pkg.sv
// Shared types and constant helpers for the QC-LDPC cyclic rotator.
package qc_rot_pkg;

   typedef enum logic {DIR_V2C = 1'b0, DIR_C2V = 1'b1} dir_e;

   // All-ones shift code marking a null (all-zero) circulant; valid for widths up to 63
   function automatic logic [63:0] null_shift(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // Largest positive two's-complement value of a w-bit lane
   function automatic logic [63:0] vc_fill(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

endpackage

// File: rtl/qc_rot_lane_sel.sv
// Source-lane index for one output lane of the cyclic rotator.
module qc_rot_lane_sel
   import qc_rot_pkg::*;
#(
   parameter int SHIFT_W = 8,
   parameter int LANE    = 0
) (
   input  dir_e               dir,
   input  logic [SHIFT_W-1:0] s,
   input  logic [SHIFT_W-1:0] z,
   output logic [SHIFT_W:0]   src,
   output logic               en
);

   localparam logic [SHIFT_W:0] LANE_I = (SHIFT_W + 1)'(LANE);

   logic [SHIFT_W:0] s_x;
   logic [SHIFT_W:0] z_x;
   logic [SHIFT_W:0] t;

   assign s_x = {1'b0, s};
   assign z_x = {1'b0, z};

   // Adding z on the inverse path keeps t non-negative, so one conditional subtract wraps it
   always_comb begin
      if (dir == DIR_V2C) t = s_x + LANE_I;
      else                t = LANE_I - s_x + z_x;
      src = (t >= z_x) ? t - z_x : t;
   end

   assign en = LANE_I < z_x;

endmodule

// File: rtl/qc_rot_pipe.sv
// Two-stage runtime-configurable cyclic rotator for one QC-LDPC circulant block.
// Optional error counter port err_cnt enabled by defining QC_ROT_ERR_CNT_EN.
module qc_rot_pipe
   import qc_rot_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int Z_MAX   = 96,
   parameter int SHIFT_W = 8,
   parameter int TAG_W   = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_dir,
   input  logic [SHIFT_W-1:0]        in_z,
   input  logic [SHIFT_W-1:0]        in_shift,
   input  logic [TAG_W-1:0]          in_tag,
   input  logic [DATA_W*Z_MAX-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [TAG_W-1:0]          out_tag,
   output logic                      out_null,
   output logic                      out_err,
   output logic [DATA_W*Z_MAX-1:0]   out_data
`ifdef QC_ROT_ERR_CNT_EN
   ,
   output logic [15:0]               err_cnt
`endif
);

   localparam int                  IDX_W   = (Z_MAX > 1) ? $clog2(Z_MAX) : 1;
   localparam logic [SHIFT_W-1:0]  NULL_S  = SHIFT_W'(null_shift(SHIFT_W));
   localparam logic [DATA_W-1:0]   VC_FILL = DATA_W'(vc_fill(DATA_W));
   localparam logic [SHIFT_W:0]    ZMAX_X  = (SHIFT_W + 1)'(Z_MAX);

   dir_e               dir_c;
   logic               is_null_c;
   logic               z_bad_c;
   logic               err_c;
   logic [SHIFT_W:0]   src_c [Z_MAX];
   logic [Z_MAX-1:0]   en_c;

   logic               vld_p1;
   logic [TAG_W-1:0]   tag_p1;
   logic               fill_p1;
   logic               err_p1;
   dir_e               dir_p1;
   logic [DATA_W-1:0]  lanes_p1 [Z_MAX];
   logic [SHIFT_W:0]   src_p1 [Z_MAX];
   logic [Z_MAX-1:0]   en_p1;

   logic               vld_p2;
   logic               s2_adv;
   logic [DATA_W-1:0]  fill_w;
   logic [DATA_W*Z_MAX-1:0] mux_c;

   assign dir_c     = dir_e'(in_dir);
   assign is_null_c = (in_shift == NULL_S);
   assign z_bad_c   = (in_z == '0) || ({1'b0, in_z} > ZMAX_X);
   assign err_c     = !is_null_c && (z_bad_c || (in_shift >= in_z));

   for (genvar g = 0; g < Z_MAX; g++) begin : g_lane
      qc_rot_lane_sel #(
         .SHIFT_W (SHIFT_W),
         .LANE    (g)
      ) u_sel (
         .dir (dir_c),
         .s   (in_shift),
         .z   (in_z),
         .src (src_c[g]),
         .en  (en_c[g])
      );
   end

   assign s2_adv    = !vld_p2 || out_ready;
   assign in_ready  = !vld_p1 || s2_adv;
   assign out_valid = vld_p2;

   // ---- stage 1: capture block, decoded flags and per-lane source index
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         tag_p1  <= in_tag;
         fill_p1 <= is_null_c || err_c;
         err_p1  <= err_c;
         dir_p1  <= dir_c;
         en_p1   <= en_c;
         for (int i = 0; i < Z_MAX; i++) begin
            lanes_p1[i] <= in_data[i*DATA_W +: DATA_W];
            src_p1[i]   <= src_c[i];
         end
      end
   end

   assign fill_w = (dir_p1 == DIR_V2C) ? VC_FILL : '0;

   always_comb begin
      mux_c = '0;
      for (int i = 0; i < Z_MAX; i++) begin
         if (en_p1[i]) begin
            if (fill_p1)
               mux_c[i*DATA_W +: DATA_W] = fill_w;
            else if (src_p1[i] < ZMAX_X)
               mux_c[i*DATA_W +: DATA_W] = lanes_p1[src_p1[i][IDX_W-1:0]];
         end
      end
   end

   // ---- stage 2: registered rotated lanes, held while downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         vld_p2   <= 1'b0;
         out_tag  <= '0;
         out_null <= 1'b0;
         out_err  <= 1'b0;
         out_data <= '0;
      end else begin
         if (in_ready) vld_p1 <= in_valid;
         if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               out_tag  <= tag_p1;
               out_null <= fill_p1;
               out_err  <= err_p1;
               out_data <= mux_c;
            end
         end
      end
   end

`ifdef QC_ROT_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt <= '0;
      else if (out_valid && out_ready && out_err && (err_cnt != 16'hFFFF))
         err_cnt <= err_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_qc_rot_pipe.sv
// Scoreboard bench for qc_rot_pipe: random and directed blocks against a lane-level rotation model.
module tb_qc_rot_pipe;

   localparam int DW = 8;
   localparam int ZM = 8;
   localparam int SW = 8;
   localparam int TW = 6;
   localparam int BW = DW * ZM;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_dir;
   logic [SW-1:0] in_z;
   logic [SW-1:0] in_shift;
   logic [TW-1:0] in_tag;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [TW-1:0] out_tag;
   logic          out_null;
   logic          out_err;
   logic [BW-1:0] out_data;
`ifdef QC_ROT_ERR_CNT_EN
   logic [15:0]   err_cnt;
   int            err_model = 0;
`endif

   qc_rot_pipe #(
      .DATA_W  (DW),
      .Z_MAX   (ZM),
      .SHIFT_W (SW),
      .TAG_W   (TW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dir    (in_dir),
      .in_z      (in_z),
      .in_shift  (in_shift),
      .in_tag    (in_tag),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tag   (out_tag),
      .out_null  (out_null),
      .out_err   (out_err),
      .out_data  (out_data)
`ifdef QC_ROT_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic          nul;
      logic          err;
      logic [BW-1:0] data;
      int            cyc;
      bit            chk_lat;
   } exp_t;

   exp_t          sbq[$];
   int            passed = 0;
   int            total  = 0;
   int            cyc    = 0;
   bit            lat_on = 1'b1;
   bit            rand_ready = 1'b0;
   bit            saw_block = 1'b0;
   logic [BW-1:0] last_out = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference: out[i] = in[(i+s) mod z] or in[(i-s) mod z] for i<z, fill on null/error, 0 above z
   function automatic exp_t model(input bit dir, input int z, input int s,
                                  input logic [TW-1:0] tag, input logic [BW-1:0] din);
      exp_t          e;
      int            src;
      logic [DW-1:0] fill;
      e.tag  = tag;
      e.data = '0;
      e.nul  = (s == 255);
      e.err  = !e.nul && (z == 0 || z > ZM || s >= z);
      if (e.err) e.nul = 1'b1;
      fill = dir ? '0 : {1'b0, {(DW-1){1'b1}}};
      for (int i = 0; i < ZM; i++) begin
         if (i < z) begin
            if (e.nul) begin
               e.data[i*DW +: DW] = fill;
            end else begin
               src = dir ? (((i - s) % z) + z) % z : (i + s) % z;
               e.data[i*DW +: DW] = din[src*DW +: DW];
            end
         end
      end
      e.cyc = 0;
      e.chk_lat = 1'b0;
      return e;
   endfunction

   function automatic logic [BW-1:0] seq(input int base);
      logic [BW-1:0] d;
      for (int i = 0; i < ZM; i++) d[i*DW +: DW] = DW'(base + i);
      return d;
   endfunction

   task automatic send(input bit dir, input int z, input int s, input logic [TW-1:0] tag,
                       input logic [BW-1:0] din, input bit ovr, input logic [BW-1:0] ovr_data);
      exp_t e;
      int   n;
      @(negedge clk);
      in_valid = 1'b1;
      in_dir   = dir;
      in_z     = SW'(z);
      in_shift = SW'(s);
      in_tag   = tag;
      in_data  = din;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", BW'(in_ready), BW'(1));
         in_valid = 1'b0;
         return;
      end
      e = model(dir, z, s, tag, din);
      if (ovr) e.data = ovr_data;
      e.cyc     = cyc;
      e.chk_lat = lat_on;
      sbq.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() > 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", BW'(sbq.size()), BW'(0));
      @(negedge clk);
   endtask

   // Monitor: pops on each output transfer and checks stability while stalled
   bit            held = 1'b0;
   logic [BW-1:0] h_data;
   logic [TW-1:0] h_tag;
   logic          h_nul, h_err;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         held = 1'b0;
      end else begin
         if (in_valid && !in_ready) saw_block = 1'b1;
         if (held) begin
            check("stall_valid", BW'(out_valid), BW'(1));
            check("stall_data", out_data, h_data);
            check("stall_tag", BW'(out_tag), BW'(h_tag));
            check("stall_flags", BW'({out_null, out_err}), BW'({h_nul, h_err}));
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("unexpected_out", BW'(out_valid), BW'(0));
            end else begin
               e = sbq.pop_front();
               check("tag", BW'(out_tag), BW'(e.tag));
               check("null", BW'(out_null), BW'(e.nul));
               check("err", BW'(out_err), BW'(e.err));
               check("data", out_data, e.data);
               if (e.chk_lat) check("latency", BW'(cyc - e.cyc), BW'(2));
`ifdef QC_ROT_ERR_CNT_EN
               check("err_cnt", BW'(err_cnt), BW'(err_model));
               if (e.err) err_model++;
`endif
               last_out = out_data;
            end
         end
         held   = out_valid && !out_ready;
         h_data = out_data;
         h_tag  = out_tag;
         h_nul  = out_null;
         h_err  = out_err;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   initial begin
      logic [BW-1:0] chain_src;
      int            z, s, q;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_dir    = 1'b0;
      in_z      = '0;
      in_shift  = '0;
      in_tag    = '0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", BW'(out_valid), BW'(0));
      check("rst_out_flags", BW'({out_null, out_err}), BW'(0));
      check("rst_out_tag", BW'(out_tag), BW'(0));
      check("rst_out_data", out_data, BW'(0));
      check("rst_in_ready", BW'(in_ready), BW'(1));
`ifdef QC_ROT_ERR_CNT_EN
      check("rst_err_cnt", BW'(err_cnt), BW'(0));
`endif

      // Directed cases: forward rotation, inverse chaining, short z, null, error
      chain_src = seq(0);
      send(1'b0, 8, 3, 6'd1, chain_src, 1'b0, '0);
      drain();
      send(1'b1, 8, 3, 6'd2, last_out, 1'b1, chain_src);
      send(1'b1, 8, 3, 6'd3, seq(0), 1'b0, '0);
      send(1'b0, 5, 4, 6'd4, seq(10), 1'b0, '0);
      send(1'b0, 8, 255, 6'd5, seq(20), 1'b0, '0);
      send(1'b1, 8, 255, 6'd6, seq(20), 1'b0, '0);
      send(1'b0, 5, 6, 6'd7, seq(30), 1'b0, '0);
      send(1'b0, 8, 0, 6'd8, seq(40), 1'b0, '0);
      send(1'b0, 8, 7, 6'd9, seq(50), 1'b0, '0);
      send(1'b1, 8, 7, 6'd10, seq(50), 1'b0, '0);
      send(1'b0, 0, 0, 6'd11, seq(60), 1'b0, '0);
      send(1'b1, 9, 2, 6'd12, seq(60), 1'b0, '0);
      drain();

      // Back-to-back with a three-cycle downstream stall
      lat_on    = 1'b0;
      saw_block = 1'b0;
      fork
         begin
            for (int k = 0; k < 4; k++) send(k[0], 8, k + 1, 6'(20 + k), seq(70 + k), 1'b0, '0);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("in_ready_drop", BW'(saw_block), BW'(1));

      // Randomized traffic with random backpressure and idle gaps
      rand_ready = 1'b1;
      for (int k = 0; k < 150; k++) begin
         z = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : $urandom_range(1, 8);
         q = $urandom_range(0, 9);
         if (q == 0)      s = 255;
         else if (q == 1) s = $urandom_range(0, 254);
         else             s = (z > 0) ? $urandom_range(0, z - 1) : 0;
         send(1'($urandom_range(0, 1)), z, s, 6'($urandom), {$urandom, $urandom}, 1'b0, '0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // Reset with two blocks in flight discards them
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(1'b0, 8, 1, 6'd40, seq(90), 1'b0, '0);
      send(1'b0, 8, 2, 6'd41, seq(91), 1'b0, '0);
      #1 rst = 1'b1;
      sbq.delete();
`ifdef QC_ROT_ERR_CNT_EN
      err_model = 0;
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_valid", BW'(out_valid), BW'(0));
      check("post_rst_in_ready", BW'(in_ready), BW'(1));
      repeat (4) begin
         @(negedge clk);
         check("post_rst_idle", BW'(out_valid), BW'(0));
      end
      lat_on = 1'b1;
      send(1'b1, 6, 5, 6'd42, seq(100), 1'b0, '0);
      send(1'b0, 5, 6, 6'd43, seq(110), 1'b0, '0);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
